parity_frame_tx: RTL and testbench

Serial frame transmitter that sits directly upstream of the parity checker.
- Accepts a parallel data word over a valid/ready handshake.
- Emits the word LSB-first on a 1-bit serial stream with a qualifying valid, followed by one parity bit computed for the selected mode.
- Drops valid low for a programmable gap between frames, so the downstream checker's bit counter resynchronises on every frame.

---
 rtl/parity_pkg.sv | 16 +
 rtl/parity_gen.sv | 15 +
 rtl/parity_frame_tx.sv | 117 +++++++++++
 tb/tb_parity_frame_tx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame transmitter and the downstream parity checker.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/parity_gen.sv
// Parity bit for one word: reduction XOR of the data, folded with the mode and an error-inject flip.
module parity_gen
  import parity_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_mode,
  input  logic              i_err_inject,
  output logic              o_parity
);

  assign o_parity = (^i_data) ^ i_mode ^ i_err_inject;

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: word sent LSB-first, then a parity bit, then a valid-low gap
// so the downstream checker resynchronises its bit counter on every frame.
module parity_frame_tx
  import parity_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic              err_inject,
  output logic              data_out,
  output logic              valid_out,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int BC_W = $clog2(DATA_W + 1);
  localparam int GC_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W);
  localparam logic [GC_W-1:0] LAST_GAP = GC_W'(GAP_CYCLES - 1);

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic              r_parity;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [GC_W-1:0]   r_gap_cnt;
  logic              r_data_out;
  logic              r_valid_out;
  logic              r_busy;
  logic [CNT_W-1:0]  r_frame_cnt;

  logic w_ready;
  logic w_accept;
  logic w_parity;

  parity_gen #(
    .DATA_W(DATA_W)
  ) u_parity_gen (
    .i_data      (in_data),
    .i_mode      (mode),
    .i_err_inject(err_inject),
    .o_parity    (w_parity)
  );

  // Ready in the final gap cycle lets a held in_valid run frames back to back.
  assign w_ready  = (r_state == IDLE) || ((r_state == GAP) && (r_gap_cnt == LAST_GAP));
  assign w_accept = in_valid && w_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_data_out  <= 1'b0;
      r_valid_out <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_data_out  <= 1'b0;
      r_valid_out <= 1'b0;
      case (r_state)
        IDLE, GAP: begin
          if ((r_state == GAP) && (r_gap_cnt != LAST_GAP)) begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end else if (w_accept) begin
            // Bit 0 goes straight to the output register; the rest wait in the shifter.
            r_state     <= DATA;
            r_shift     <= in_data >> 1;
            r_parity    <= w_parity;
            r_bit_cnt   <= BC_W'(1);
            r_data_out  <= in_data[0];
            r_valid_out <= 1'b1;
            r_busy      <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        DATA: begin
          r_valid_out <= 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            r_data_out  <= r_parity;
            r_state     <= PAR;
            r_frame_cnt <= r_frame_cnt + 1'b1;
          end else begin
            r_data_out <= r_shift[0];
            r_shift    <= r_shift >> 1;
            r_bit_cnt  <= r_bit_cnt + 1'b1;
          end
        end
        PAR: begin
          r_state   <= GAP;
          r_gap_cnt <= '0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = w_ready;
  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign busy      = r_busy;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: directed and random frames checked cycle by cycle against a
// bit-timeline model plus a downstream parity-checker model.
module tb_parity_frame_tx;

  localparam int DATA_W     = 8;
  localparam int GAP_CYCLES = 1;
  localparam int CNT_W      = 4;
  localparam int FRAME_LEN  = DATA_W + 1 + GAP_CYCLES;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              mode = 1'b0;
  logic              err_inject = 1'b0;
  logic              in_ready;
  logic              data_out;
  logic              valid_out;
  logic              busy;
  logic [CNT_W-1:0]  frame_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  parity_frame_tx #(
    .DATA_W    (DATA_W),
    .GAP_CYCLES(GAP_CYCLES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .err_inject(err_inject),
    .data_out  (data_out),
    .valid_out (valid_out),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  // Model state: expected serial timeline entries {is_parity, bit}, per-frame {mode, err}.
  logic [1:0]       exp_q[$];
  logic [1:0]       info_q[$];
  int               start_q[$];
  int               m_left = 0;
  logic [CNT_W-1:0] m_frames = '0;
  logic             m_acc = 1'b0;
  int               obs_n = 0;
  int               obs_ones = 0;
  logic             last_par_obs = 1'b0;
  logic             prev_valid = 1'b0;
  int               cyc = 0;
  int               n_sent = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Bit that makes the total count of ones even (mode 0) or odd (mode 1), optionally inverted.
  function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic md, input logic er);
    int ones;
    ones = $countones(d);
    return (((ones + int'(md)) % 2) == 1) ^ er;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    info_q.delete();
    m_left   = 0;
    m_frames = '0;
    obs_n    = 0;
    obs_ones = 0;
    prev_valid = 1'b0;
  endtask

  task automatic model_edge();
    m_acc = 1'b0;
    if (!reset) begin
      model_clear();
      return;
    end
    m_acc = in_valid && (m_left <= 1);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (m_acc) begin
      for (int i = 0; i < DATA_W; i++) exp_q.push_back({1'b0, in_data[i]});
      exp_q.push_back({1'b1, parity_bit(in_data, mode, err_inject)});
      info_q.push_back({mode, err_inject});
      m_left = FRAME_LEN;
      n_sent++;
      $display("tx %0d @%0d: data=%h mode=%0d err=%0d", n_sent, cyc, in_data, mode, err_inject);
    end else if (m_left > 0) begin
      m_left--;
    end
    if (exp_q.size() > 0 && exp_q[0][1]) m_frames++;
  endtask

  task automatic check_cycle();
    logic ev;
    logic ed;
    logic flag;
    ev = (exp_q.size() > 0);
    ed = ev ? exp_q[0][0] : 1'b0;
    chk("valid_out", 32'(valid_out), 32'(ev));
    chk("data_out", 32'(data_out), 32'(ed));
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("in_ready", 32'(in_ready), 32'(m_left <= 1));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    if (valid_out === 1'b1) begin
      if (prev_valid !== 1'b1) start_q.push_back(cyc);
      obs_n++;
      obs_ones += int'(data_out);
      last_par_obs = data_out;
    end else if (obs_n > 0) begin
      chk("frame_len", 32'(obs_n), 32'(DATA_W + 1));
      if (info_q.size() > 0) begin
        flag = ((obs_ones % 2) == 1) != info_q[0][1];
        chk("checker_flag", 32'(flag), 32'(info_q[0][0]));
        void'(info_q.pop_front());
      end
      obs_n    = 0;
      obs_ones = 0;
    end
    prev_valid = valid_out;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    check_cycle();
  endtask

  // Present a word and step until it is taken; keep=1 leaves in_valid high for back-to-back use.
  task automatic send(input logic [DATA_W-1:0] d, input logic md, input logic er, input bit keep);
    int guard;
    guard = 0;
    in_data = d;
    mode = md;
    err_inject = er;
    in_valid = 1'b1;
    m_acc = 1'b0;
    while (!m_acc && guard < 4 * FRAME_LEN) begin
      tick();
      guard++;
    end
    chk("accept_seen", 32'(m_acc), 32'(1));
    if (!keep) begin
      in_valid   = 1'b0;
      in_data    = DATA_W'($urandom);
      mode       = 1'($urandom);
      err_inject = 1'($urandom);
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    in_valid = 1'b0;
    while (m_left != 0 && guard < 4 * FRAME_LEN) begin
      tick();
      guard++;
    end
    tick();
  endtask

  initial begin
    // Reset values, then first cycle after release.
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_out", 32'(valid_out), 32'(0));
    chk("rst_data_out", 32'(data_out), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_frame_cnt", 32'(frame_cnt), 32'(0));
    reset = 1'b1;
    tick();

    // Even frame A5.
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    wait_idle();
    chk("a5_parity", 32'(last_par_obs), 32'(0));
    chk("a5_frame_cnt", 32'(frame_cnt), 32'(1));

    // Odd mode, then error inject (checker model must flag the second).
    send(8'h07, 1'b1, 1'b0, 1'b0);
    wait_idle();
    chk("07_odd_parity", 32'(last_par_obs), 32'(0));
    send(8'h07, 1'b0, 1'b1, 1'b0);
    wait_idle();
    chk("07_err_parity", 32'(last_par_obs), 32'(0));

    // Back-to-back with in_valid held high.
    start_q.delete();
    send(8'h3C, 1'b0, 1'b0, 1'b1);
    send(8'hC3, 1'b1, 1'b0, 1'b1);
    send(8'h81, 1'b0, 1'b1, 1'b1);
    send(8'h7E, 1'b1, 1'b1, 1'b0);
    wait_idle();
    chk("b2b_frames", 32'(start_q.size()), 32'(4));
    for (int i = 1; i < start_q.size(); i++)
      chk("b2b_period", 32'(start_q[i] - start_q[i-1]), 32'(FRAME_LEN));

    // Random traffic with mid-frame input churn.
    for (int k = 0; k < 30; k++) begin
      bit keep;
      keep = 1'($urandom);
      send(DATA_W'($urandom), 1'($urandom), 1'($urandom), keep);
      if (!keep) repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle();

    // Reset during data bit 4 of FF.
    send(8'hFF, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    chk("pre_rst_valid", 32'(valid_out), 32'(1));
    #1 reset = 1'b0;
    #1;
    chk("midrst_valid_out", 32'(valid_out), 32'(0));
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    model_clear();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    send(8'h01, 1'b0, 1'b0, 1'b0);
    wait_idle();
    chk("01_parity", 32'(last_par_obs), 32'(1));
    chk("01_frame_cnt", 32'(frame_cnt), 32'(1));

    // Frame counter wrap at CNT_W=4.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int k = 1; k <= 17; k++) begin
      send(DATA_W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      if (k >= 15) begin
        wait_idle();
        chk("wrap_frame_cnt", 32'(frame_cnt), 32'(k % 16));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
